// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze/halt sequencer for the 5-stage pipeline, with per-stage valid tracking.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  rs1_Dec,
  input  logic [4:0]  rs2_Dec,
  input  logic        rs1_used_Dec,
  input  logic        rs2_used_Dec,
  input  logic [4:0]  Rd_Exec,
  input  logic        wrEn_Exec,
  input  logic        load_Exec,
  input  logic        npc_control_Dec,
  input  logic        halt_IF,
  input  logic        mem_busy_Mem,
  output logic        stall,
  output logic        bubble_Exec,
  output logic        flush_Dec,
  output logic        freeze,
  output logic        valid_Dec,
  output logic        valid_Exec,
  output logic        valid_Mem,
  output logic        valid_WB,
  output logic        halt_out,
  output logic        mem_err,
  output logic [2:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] freeze_cnt
);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_FREEZE = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_HALTED = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;
  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  logic [2:0] state_q, state_d;
  logic       v_dec_q, v_dec_d, v_exec_q, v_exec_d;
  logic       v_mem_q, v_mem_d, v_wb_q, v_wb_d;
  logic       mem_err_q, mem_err_d;
  logic [7:0] frz_cnt_q, frz_cnt_d;

  logic terminal, run_like, lu, frz, do_flush, halt_go, timeout;

  always_comb begin
    terminal = (state_q == ST_HALTED) || (state_q == ST_ERROR);
    run_like = (state_q == ST_RUN) || (state_q == ST_FREEZE);
    frz      = !terminal && mem_busy_Mem && v_mem_q;
    lu       = v_dec_q && v_exec_q && load_Exec && wrEn_Exec && (Rd_Exec != 5'd0) &&
               ((rs1_used_Dec && (rs1_Dec == Rd_Exec)) ||
                (rs2_used_Dec && (rs2_Dec == Rd_Exec)));
    do_flush = !frz && !lu && npc_control_Dec && v_dec_q;
    // A halt fetched beside a redirect is wrong-path; beside a load-use it is retried later.
    halt_go  = run_like && halt_IF && !frz && !lu && !npc_control_Dec;
    timeout  = frz && ((frz_cnt_q + 8'd1) == TIMEOUT_C);
  end

  assign stall       = rstn && (terminal || frz || lu || (state_q == ST_DRAIN));
  assign freeze      = rstn && (terminal || frz);
  assign bubble_Exec = rstn && !frz && lu;
  assign flush_Dec   = rstn && do_flush;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    v_dec_d   = v_dec_q;
    v_exec_d  = v_exec_q;
    v_mem_d   = v_mem_q;
    v_wb_d    = v_wb_q;
    mem_err_d = mem_err_q || timeout;
    frz_cnt_d = frz ? frz_cnt_q + 8'd1 : 8'd0;

    if (terminal || timeout) begin
      if (timeout) state_d = ST_ERROR;
      v_dec_d  = 1'b0;
      v_exec_d = 1'b0;
      v_mem_d  = 1'b0;
      v_wb_d   = 1'b0;
    end else if (frz) begin
      if (state_q == ST_RUN) state_d = ST_FREEZE;
    end else begin
      if (halt_go) state_d = ST_DRAIN;
      else if (state_q == ST_FREEZE) state_d = ST_RUN;
      else if ((state_q == ST_DRAIN) && !(v_exec_q || v_mem_q || v_wb_q)) state_d = ST_HALTED;

      v_wb_d  = v_mem_q;
      v_mem_d = v_exec_q;
      if (lu) begin
        v_exec_d = 1'b0;
      end else if (do_flush) begin
        v_exec_d = v_dec_q;
        v_dec_d  = 1'b0;
      end else begin
        v_exec_d = v_dec_q;
        v_dec_d  = run_like && !halt_go;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rstn) begin
      state_q   <= ST_RUN;
      v_dec_q   <= 1'b0;
      v_exec_q  <= 1'b0;
      v_mem_q   <= 1'b0;
      v_wb_q    <= 1'b0;
      mem_err_q <= 1'b0;
      frz_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      v_dec_q   <= v_dec_d;
      v_exec_q  <= v_exec_d;
      v_mem_q   <= v_mem_d;
      v_wb_q    <= v_wb_d;
      mem_err_q <= mem_err_d;
      frz_cnt_q <= frz_cnt_d;
    end
  end

  assign valid_Dec  = v_dec_q;
  assign valid_Exec = v_exec_q;
  assign valid_Mem  = v_mem_q;
  assign valid_WB   = v_wb_q;
  assign state      = state_q;
  assign halt_out   = (state_q == ST_HALTED);
  assign mem_err    = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  // Saturating counters: a wrapped count would read as a near-idle pipe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_q  <= 16'h0000;
      flush_cnt_q  <= 16'h0000;
      freeze_cnt_q <= 16'h0000;
    end else begin
      if (lu && (stall_cnt_q != 16'hFFFF))       stall_cnt_q  <= stall_cnt_q + 16'd1;
      if (do_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q  <= flush_cnt_q + 16'd1;
      if (frz && (freeze_cnt_q != 16'hFFFF))     freeze_cnt_q <= freeze_cnt_q + 16'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`else
  assign stall_cnt  = 16'h0000;
  assign flush_cnt  = 16'h0000;
  assign freeze_cnt = 16'h0000;
`endif

endmodule
